// File: rtl/trv_arbiter.sv
// trv_arbiter: shares one traversal engine among NUM_THREADS reorder units.
//   - Init requests from the per-thread FWFT FIFOs are granted round-robin into a
//     single registered init request stream (1 cycle latency, no bubbles).
//   - Traversal responses are routed back to the owning unit by their TID field.
//   - Per-thread outstanding counters cap in-flight rays at MAX_OUTSTANDING.
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   req_in_*                    per-thread init request FIFOs (empty_n/read/dout)
//   init_req_stream_*           registered init request stream to the engine
//   trv_resp_stream_*           response stream from the engine
//   resp_out_*                  per-thread response sinks (data broadcast)
//   err                         sticky: [0] bad resp TID, [1] resp with no
//                               outstanding request, [2] request TID != lane

`ifndef TID_WIDTH
`define TID_WIDTH 3
`endif
`ifndef INIT_REQ_WIDTH
`define INIT_REQ_WIDTH 16
`endif
`ifndef TRV_RESP_WIDTH
`define TRV_RESP_WIDTH 16
`endif

module trv_arbiter #(
  parameter int unsigned NUM_THREADS     = 4,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                                      clk,
  input  logic                                      arst_n,
  input  logic [NUM_THREADS-1:0]                    req_in_empty_n,
  output logic [NUM_THREADS-1:0]                    req_in_read,
  input  logic [NUM_THREADS*`INIT_REQ_WIDTH-1:0]    req_in_dout,
  input  logic                                      init_req_stream_full_n,
  output logic                                      init_req_stream_write,
  output logic [`INIT_REQ_WIDTH-1:0]                init_req_stream_din,
  input  logic                                      trv_resp_stream_empty_n,
  output logic                                      trv_resp_stream_read,
  input  logic [`TRV_RESP_WIDTH-1:0]                trv_resp_stream_dout,
  input  logic [NUM_THREADS-1:0]                    resp_out_full_n,
  output logic [NUM_THREADS-1:0]                    resp_out_write,
  output logic [`TRV_RESP_WIDTH-1:0]                resp_out_din,
  output logic [2:0]                                err
);

  localparam int unsigned IW = `INIT_REQ_WIDTH;
  localparam int unsigned TW = `TID_WIDTH;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic                   out_valid_q, out_valid_d;
  logic [IW-1:0]          out_data_q, out_data_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          cnt_q [NUM_THREADS];
  logic [CW-1:0]          cnt_d [NUM_THREADS];
  logic [2:0]             err_q, err_d;

  logic                   slot_free;
  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] gnt;
  logic                   gnt_any;
  logic [IW-1:0]          gnt_data;
  logic                   lane_tid_bad;
  logic [TW-1:0]          resp_tid;
  logic                   tid_ok;
  logic [NUM_THREADS-1:0] resp_hit;

  // A new request may enter the output register when it is empty or being drained.
  assign slot_free = ~out_valid_q | init_req_stream_full_n;

  always_comb begin
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      eligible[i] = req_in_empty_n[i] && (32'(cnt_q[i]) < MAX_OUTSTANDING);
    end
  end

  // Round-robin: scan rr_ptr, rr_ptr+1, ... and take the first eligible thread.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_THREADS; k++) begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        if (slot_free && !gnt_any && eligible[i] &&
            (i == (32'(rr_ptr_q) + k) % NUM_THREADS)) begin
          gnt[i]   = 1'b1;
          gnt_any  = 1'b1;
          rr_ptr_d = PW'((i + 1) % NUM_THREADS);
        end
      end
    end
  end

  always_comb begin
    gnt_data     = '0;
    lane_tid_bad = 1'b0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      if (gnt[i]) begin
        gnt_data     = req_in_dout[i*IW +: IW];
        lane_tid_bad = (32'(req_in_dout[i*IW +: TW]) != i);
      end
    end
  end

  assign req_in_read = gnt;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (gnt_any) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
    end else if (init_req_stream_full_n) begin
      out_valid_d = 1'b0;
    end
  end

  assign init_req_stream_write = out_valid_q;
  assign init_req_stream_din   = out_data_q;

  // Response routing is purely combinational; out-of-range TIDs are popped and dropped.
  assign resp_tid = trv_resp_stream_dout[TW-1:0];
  assign tid_ok   = (32'(resp_tid) < NUM_THREADS);

  always_comb begin
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      resp_hit[i] = (32'(resp_tid) == i);
    end
  end

  assign trv_resp_stream_read = trv_resp_stream_empty_n &
                                (~tid_ok | (|(resp_hit & resp_out_full_n)));
  assign resp_out_write       = resp_hit & {NUM_THREADS{trv_resp_stream_read}};
  assign resp_out_din         = trv_resp_stream_dout;

  always_comb begin
    err_d = err_q;
    if (trv_resp_stream_read && !tid_ok) err_d[0] = 1'b1;
    if (gnt_any && lane_tid_bad)         err_d[2] = 1'b1;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && !resp_out_write[i]) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else if (!gnt[i] && resp_out_write[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
      // Spurious response: still delivered, counter saturates at zero.
      if (resp_out_write[i] && (cnt_q[i] == '0)) err_d[1] = 1'b1;
    end
  end

  assign err = err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
      err_q       <= '0;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_trv_arbiter.sv
// Scoreboard bench for trv_arbiter: stimulus pushes expected init requests and
// routed responses into queues; a negedge monitor pops and compares them.

`ifndef TID_WIDTH
`define TID_WIDTH 3
`endif
`ifndef INIT_REQ_WIDTH
`define INIT_REQ_WIDTH 16
`endif
`ifndef TRV_RESP_WIDTH
`define TRV_RESP_WIDTH 16
`endif

module tb_trv_arbiter;
  localparam int unsigned N    = 4;
  localparam int unsigned MAXO = 4;
  localparam int unsigned IW   = `INIT_REQ_WIDTH;
  localparam int unsigned RW   = `TRV_RESP_WIDTH;

  logic            clk;
  logic            arst_n;
  logic [N-1:0]    req_in_empty_n;
  logic [N-1:0]    req_in_read;
  logic [N*IW-1:0] req_in_dout;
  logic            init_req_stream_full_n;
  logic            init_req_stream_write;
  logic [IW-1:0]   init_req_stream_din;
  logic            trv_resp_stream_empty_n;
  logic            trv_resp_stream_read;
  logic [RW-1:0]   trv_resp_stream_dout;
  logic [N-1:0]    resp_out_full_n;
  logic [N-1:0]    resp_out_write;
  logic [RW-1:0]   resp_out_din;
  logic [2:0]      err;

  trv_arbiter #(
    .NUM_THREADS     (N),
    .MAX_OUTSTANDING (MAXO)
  ) u_dut (
    .clk                     (clk),
    .arst_n                  (arst_n),
    .req_in_empty_n          (req_in_empty_n),
    .req_in_read             (req_in_read),
    .req_in_dout             (req_in_dout),
    .init_req_stream_full_n  (init_req_stream_full_n),
    .init_req_stream_write   (init_req_stream_write),
    .init_req_stream_din     (init_req_stream_din),
    .trv_resp_stream_empty_n (trv_resp_stream_empty_n),
    .trv_resp_stream_read    (trv_resp_stream_read),
    .trv_resp_stream_dout    (trv_resp_stream_dout),
    .resp_out_full_n         (resp_out_full_n),
    .resp_out_write          (resp_out_write),
    .resp_out_din            (resp_out_din),
    .err                     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned       n_checks = 0;
  int unsigned       n_fail   = 0;
  logic [IW-1:0]     exp_init[$];
  logic [N+RW-1:0]   exp_resp[$];
  logic [7:0]        seq [N];
  logic [N-1:0]      lane_en;
  logic [N-1:0]      bad_tid;
  logic [IW-1:0]     held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane payload: sequence number on top, TID field (normally the lane index) at the bottom.
  function automatic logic [IW-1:0] lane_data(input int i);
    logic [2:0] tid;
    tid = bad_tid[i] ? 3'(i + 1) : 3'(i);
    return {seq[i], 5'd0, tid};
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      req_in_empty_n[i]         = lane_en[i];
      req_in_dout[i*IW +: IW]   = lane_data(i);
    end
  endtask

  task automatic set_lanes(input logic [N-1:0] m);
    lane_en = m;
    drive_lanes();
  endtask

  task automatic set_resp(input logic [2:0] tid, input logic [12:0] hi);
    trv_resp_stream_empty_n = 1'b1;
    trv_resp_stream_dout    = {hi, tid};
  endtask

  task automatic clr_resp();
    trv_resp_stream_empty_n = 1'b0;
    trv_resp_stream_dout    = '0;
  endtask

  // One clock: entered and left at posedge+1; samples combinational handshakes at negedge+1.
  task automatic cycle(input logic [N-1:0] exp_rd, input logic exp_rsp_rd);
    logic [N-1:0] rd;
    @(negedge clk);
    #1;
    rd = req_in_read;
    check("req_in_read", 32'(rd), 32'(exp_rd));
    check("trv_resp_read", 32'(trv_resp_stream_read), 32'(exp_rsp_rd));
    for (int i = 0; i < N; i++) begin
      if (exp_rd[i]) exp_init.push_back(lane_data(i));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i]) seq[i] = seq[i] + 8'd1;
    end
    drive_lanes();
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    check("rst_write", 32'(init_req_stream_write), 32'd0);
    check("rst_din", 32'(init_req_stream_din), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    exp_init.delete();
    exp_resp.delete();
    bad_tid                = '0;
    init_req_stream_full_n = 1'b1;
    resp_out_full_n        = '1;
    clr_resp();
    set_lanes('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      if (init_req_stream_write && init_req_stream_full_n) begin
        if (exp_init.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL init_unexpected: got din %h, none expected", init_req_stream_din);
        end else begin
          check("init_din", 32'(init_req_stream_din), 32'(exp_init.pop_front()));
        end
      end
      if (|resp_out_write) begin
        if (exp_resp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: got write %b din %h, none expected",
                   resp_out_write, resp_out_din);
        end else begin
          check("resp_out", 32'({resp_out_write, resp_out_din}), 32'(exp_resp.pop_front()));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) seq[i] = 8'(16 * i + 1);
    lane_en = '0;
    bad_tid = '0;
    drive_lanes();
    do_reset();

    // All lanes busy: grants 0,1,2,3,0,... with write high every cycle.
    set_lanes(4'b1111);
    for (int r = 0; r < 8; r++) begin
      cycle(4'b0001 << (r % 4), 1'b0);
      check("rr_write", 32'(init_req_stream_write), 32'd1);
    end
    // Reset with an output still pending: it is discarded.
    do_reset();

    // Threads 1 and 3 with rr_ptr moved to 2 by one grant to thread 1.
    set_lanes(4'b0010);
    cycle(4'b0010, 1'b0);
    set_lanes(4'b1010);
    cycle(4'b1000, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b1000, 1'b0);
    cycle(4'b0010, 1'b0);
    set_lanes('0);
    cycle(4'b0000, 1'b0);
    check("rr13_drain", exp_init.size(), 0);
    do_reset();

    // Outstanding cap: MAXO grants, then stall until a response frees a slot.
    set_lanes(4'b0001);
    for (int r = 0; r < MAXO; r++) cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    set_resp(3'd0, 13'h0A5);
    exp_resp.push_back({4'b0001, 13'h0A5, 3'd0});
    cycle(4'b0000, 1'b1);
    clr_resp();
    cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);
    set_lanes('0);
    cycle(4'b0000, 1'b0);
    check("cap_drain", exp_init.size(), 0);
    check("cap_resp_drain", exp_resp.size(), 0);
    do_reset();

    // Engine backpressure: output held, no grants; release accepts and regrants at once.
    set_lanes(4'b0100);
    held = lane_data(2);
    cycle(4'b0100, 1'b0);
    init_req_stream_full_n = 1'b0;
    for (int r = 0; r < 5; r++) begin
      cycle(4'b0000, 1'b0);
      check("bp_write", 32'(init_req_stream_write), 32'd1);
      check("bp_din", 32'(init_req_stream_din), 32'(held));
    end
    init_req_stream_full_n = 1'b1;
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    set_lanes('0);
    cycle(4'b0000, 1'b0);
    check("bp_drain", exp_init.size(), 0);

    // Response to thread 2 blocked by its sink, then delivered; cnt[2] goes 3 -> 2.
    resp_out_full_n = 4'b1011;
    set_resp(3'd2, 13'h1234);
    for (int r = 0; r < 3; r++) cycle(4'b0000, 1'b0);
    resp_out_full_n = 4'b1111;
    exp_resp.push_back({4'b0100, 13'h1234, 3'd2});
    cycle(4'b0000, 1'b1);
    clr_resp();
    set_lanes(4'b0100);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    set_lanes('0);
    cycle(4'b0000, 1'b0);
    check("resp2_drain", exp_resp.size(), 0);
    check("resp2_err", 32'(err), 32'd0);

    // Out-of-range TID dropped; response with nothing outstanding; lane TID mismatch.
    set_resp(3'd7, 13'h0777);
    cycle(4'b0000, 1'b1);
    clr_resp();
    check("err_tid", 32'(err), 32'b001);
    set_resp(3'd1, 13'h0111);
    exp_resp.push_back({4'b0010, 13'h0111, 3'd1});
    cycle(4'b0000, 1'b1);
    clr_resp();
    check("err_zero_cnt", 32'(err), 32'b011);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    check("err_sticky", 32'(err), 32'b011);
    bad_tid = 4'b1000;
    set_lanes(4'b1000);
    cycle(4'b1000, 1'b0);
    set_lanes('0);
    check("err_lane", 32'(err), 32'b111);
    cycle(4'b0000, 1'b0);
    check("lane_drain", exp_init.size(), 0);
    do_reset();
    check("err_cleared", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
